// File: rtl/ibex_pext_mult_seq.sv
// Request/response sequencer for the multi-cycle P-extension multiplier: latches one
// request, holds the multiplier enabled for MultLatency cycles, then presents the result.
module ibex_pext_mult_seq #(
  parameter int unsigned MultLatency = 2,
  parameter int unsigned OpWidth     = 7,
  parameter int unsigned SignWidth   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_op_a_i,
  input  logic [31:0]          req_op_b_i,
  input  logic [OpWidth-1:0]   req_operator_i,
  input  logic [SignWidth-1:0] req_signed_i,

  output logic                 mult_en_o,
  output logic [31:0]          mult_op_a_o,
  output logic [31:0]          mult_op_b_o,
  output logic [OpWidth-1:0]   mult_operator_o,
  output logic [SignWidth-1:0] mult_signed_o,
  input  logic [31:0]          mult_result_i,

  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [31:0]          resp_result_o,

  output logic                 busy_o,
  output logic [15:0]          op_count_o
);

  localparam int unsigned           CntWidth = $clog2(MultLatency + 1);
  localparam logic [CntWidth-1:0]   CntLoad  = CntWidth'(MultLatency - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CntWidth-1:0]    r_cnt;
  logic [31:0]            r_op_a;
  logic [31:0]            r_op_b;
  logic [OpWidth-1:0]     r_operator;
  logic [SignWidth-1:0]   r_signed;
  logic [31:0]            r_result;
  logic [15:0]            r_op_count;

  logic                   w_accept;
  logic                   w_resp_hs;
  logic                   w_capture;

  // A response handshake is suppressed by flush so the count only sees delivered results.
  assign w_accept  = req_valid_i & req_ready_o;
  assign w_resp_hs = (r_state == ST_RESP) & resp_ready_i & ~flush_i;
  assign w_capture = (r_state == ST_BUSY) & (r_cnt == '0) & ~flush_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through this block leaves the signal unassigned (no latch).
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
        ST_BUSY: if (r_cnt == '0) w_state_next = ST_RESP;
        ST_RESP: if (resp_ready_i) w_state_next = w_accept ? ST_BUSY : ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    req_ready_o  = 1'b0;
    mult_en_o    = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: req_ready_o  = ~flush_i;
      ST_BUSY: mult_en_o    = 1'b1;
      ST_RESP: begin
        resp_valid_o = 1'b1;
        req_ready_o  = ~flush_i & resp_ready_i;
      end
      default: ;
    endcase
  end

  // Latency counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CntLoad;
    end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Multiplier operand registers: loaded only by an accepted request, untouched by flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_operator <= '0;
      r_signed   <= '0;
    end else if (w_accept) begin
      r_op_a     <= req_op_a_i;
      r_op_b     <= req_op_b_i;
      r_operator <= req_operator_i;
      r_signed   <= req_signed_i;
    end
  end

  // Result capture and completed-response counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_result   <= '0;
      r_op_count <= '0;
    end else begin
      if (w_capture) r_result <= mult_result_i;
      if (w_resp_hs) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign mult_op_a_o     = r_op_a;
  assign mult_op_b_o     = r_op_b;
  assign mult_operator_o = r_operator;
  assign mult_signed_o   = r_signed;
  assign resp_result_o   = r_result;
  assign op_count_o      = r_op_count;

endmodule

// File: tb/tb_ibex_pext_mult_seq.sv
// Self-checking bench for ibex_pext_mult_seq; the stand-in multiplier returns A^B and a
// timestamp-based reference model predicts handshakes, latency and the response counter.
module tb_ibex_pext_mult_seq;

  localparam int L  = 2;
  localparam int OW = 7;
  localparam int SW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_op_a_i;
  logic [31:0]   req_op_b_i;
  logic [OW-1:0] req_operator_i;
  logic [SW-1:0] req_signed_i;
  logic          mult_en_o;
  logic [31:0]   mult_op_a_o;
  logic [31:0]   mult_op_b_o;
  logic [OW-1:0] mult_operator_o;
  logic [SW-1:0] mult_signed_o;
  logic [31:0]   mult_result_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [31:0]   resp_result_o;
  logic          busy_o;
  logic [15:0]   op_count_o;

  ibex_pext_mult_seq #(.MultLatency(L), .OpWidth(OW), .SignWidth(SW)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_op_a_i      (req_op_a_i),
    .req_op_b_i      (req_op_b_i),
    .req_operator_i  (req_operator_i),
    .req_signed_i    (req_signed_i),
    .mult_en_o       (mult_en_o),
    .mult_op_a_o     (mult_op_a_o),
    .mult_op_b_o     (mult_op_b_o),
    .mult_operator_o (mult_operator_o),
    .mult_signed_o   (mult_signed_o),
    .mult_result_i   (mult_result_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_result_o   (resp_result_o),
    .busy_o          (busy_o),
    .op_count_o      (op_count_o)
  );

  always #5 clk_i = ~clk_i;

  assign mult_result_i = mult_op_a_o ^ mult_op_b_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] exp_count;

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [OW-1:0] op, input logic [SW-1:0] sg);
    req_op_a_i     = a;
    req_op_b_i     = b;
    req_operator_i = op;
    req_signed_i   = sg;
    req_valid_i    = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [OW-1:0] op, input logic [SW-1:0] sg);
    drive_req(a, b, op, sg);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output int waited);
    waited = 0;
    while (!resp_valid_o && waited < budget) begin
      step();
      waited++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    req_op_a_i = '0; req_op_b_i = '0; req_operator_i = '0; req_signed_i = '0;
    step(); step();
    rst_ni = 1'b1;
    #1;
    exp_count = 16'd0;
    checks++; if (mult_en_o !== 1'b0) begin errors++; $display("FAIL reset_mult_en: got %b expected 0", mult_en_o); end
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready_o); end
    checks++; if (op_count_o !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %h expected 0", op_count_o); end
    checks++; if (resp_result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", resp_result_o); end
    checks++; if ({mult_op_a_o, mult_op_b_o, mult_operator_o, mult_signed_o} !== '0)
      begin errors++; $display("FAIL reset_mult_regs: got %h %h %h %h expected 0", mult_op_a_o, mult_op_b_o, mult_operator_o, mult_signed_o); end
  endtask

  task automatic test_single();
    resp_ready_i = 1'b1;
    drive_req(32'h820111dc, 32'h05057fca, 7'h15, 2'b01);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL single_req_ready: got %b expected 1", req_ready_o); end
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < L; i++) begin
      checks++; if (mult_en_o !== 1'b1) begin errors++; $display("FAIL single_mult_en cycle %0d: got %b expected 1", i + 1, mult_en_o); end
      checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid cycle %0d: got %b expected 0", i + 1, resp_valid_o); end
      checks++; if (mult_op_a_o !== 32'h820111dc || mult_operator_o !== 7'h15 || mult_signed_o !== 2'b01)
        begin errors++; $display("FAIL single_mult_regs: got %h %h %b", mult_op_a_o, mult_operator_o, mult_signed_o); end
      step();
    end
    checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", resp_valid_o); end
    checks++; if (resp_result_o !== 32'h87046e16) begin errors++; $display("FAIL single_result: got %h expected 87046e16", resp_result_o); end
    checks++; if (mult_en_o !== 1'b0) begin errors++; $display("FAIL single_mult_en_drop: got %b expected 0", mult_en_o); end
    step();
    exp_count++;
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL single_op_count: got %h expected %h", op_count_o, exp_count); end
    checks++; if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b valid %b expected 0 0", busy_o, resp_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    int w;
    a = $urandom; b = $urandom;
    resp_ready_i = 1'b0;
    issue(a, b, 7'h3, 2'b10);
    wait_resp(20, w);
    checks++; if (!resp_valid_o || w != L) begin errors++; $display("FAIL bp_latency: got valid %b after %0d cycles expected %0d", resp_valid_o, w, L); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid_o !== 1'b1 || resp_result_o !== (a ^ b))
        begin errors++; $display("FAIL bp_hold cycle %0d: got %b %h expected 1 %h", i, resp_valid_o, resp_result_o, a ^ b); end
      checks++; if (req_ready_o !== 1'b0 || mult_en_o !== 1'b0)
        begin errors++; $display("FAIL bp_ready_en cycle %0d: got ready %b en %b expected 0 0", i, req_ready_o, mult_en_o); end
      checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL bp_count_hold: got %h expected %h", op_count_o, exp_count); end
      step();
    end
    resp_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready_o); end
    step();
    exp_count++;
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL bp_op_count: got %h expected %h", op_count_o, exp_count); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy %b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    logic [31:0] a [N];
    logic [31:0] b [N];
    logic [31:0] q [$];
    int idx, got, first_acc, last_acc, lows;
    for (int i = 0; i < N; i++) begin a[i] = $urandom; b[i] = $urandom; end
    idx = 0; got = 0; first_acc = -1; last_acc = 0; lows = 0;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 60 && got < N; c++) begin
      if (idx < N) drive_req(a[idx], b[idx], OW'(idx), SW'(idx));
      else req_valid_i = 1'b0;
      #1;
      if (first_acc >= 0 && idx < N && !mult_en_o) lows++;
      if (resp_valid_o) begin
        checks++;
        if (q.size() == 0 || resp_result_o !== q[0]) begin
          errors++; $display("FAIL b2b_order resp %0d: got %h expected %h", got, resp_result_o, (q.size() != 0) ? q[0] : 32'hx);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
        exp_count++;
      end
      if (req_valid_i && req_ready_o) begin
        if (idx > 0) begin
          checks++; if (cyc - last_acc != L + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_acc, L + 1); end
          checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_same_cycle: got resp_valid %b expected 1", resp_valid_o); end
        end else begin
          first_acc = cyc;
        end
        last_acc = cyc;
        q.push_back(a[idx] ^ b[idx]);
        idx++;
      end
      step();
    end
    req_valid_i = 1'b0;
    checks++; if (got != N) begin errors++; $display("FAIL b2b_timeout: got %0d responses expected %0d", got, N); end
    checks++; if (lows != N - 1) begin errors++; $display("FAIL b2b_en_gap: got %0d low cycles expected %0d", lows, N - 1); end
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL b2b_op_count: got %h expected %h", op_count_o, exp_count); end
  endtask

  task automatic test_flush_busy();
    logic [31:0] a, b;
    int w;
    a = $urandom; b = $urandom;
    resp_ready_i = 1'b1;
    issue(a, b, 7'h11, 2'b11);
    flush_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b0 || mult_en_o !== 1'b1) begin errors++; $display("FAIL fb_during: got ready %b en %b expected 0 1", req_ready_o, mult_en_o); end
    step();
    flush_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || mult_en_o !== 1'b0) begin errors++; $display("FAIL fb_after: got busy %b en %b expected 0 0", busy_o, mult_en_o); end
    checks++; if (mult_op_a_o !== a || mult_op_b_o !== b) begin errors++; $display("FAIL fb_regs_kept: got %h %h expected %h %h", mult_op_a_o, mult_op_b_o, a, b); end
    for (int i = 0; i < L + 2; i++) begin
      checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL fb_no_resp cycle %0d: got %b expected 0", i, resp_valid_o); end
      step();
    end
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL fb_count: got %h expected %h", op_count_o, exp_count); end
    a = $urandom; b = $urandom;
    issue(a, b, 7'h2, 2'b00);
    wait_resp(20, w);
    checks++; if (!resp_valid_o || resp_result_o !== (a ^ b)) begin errors++; $display("FAIL fb_next_op: got %b %h expected 1 %h", resp_valid_o, resp_result_o, a ^ b); end
    step();
    exp_count++;
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL fb_next_count: got %h expected %h", op_count_o, exp_count); end
  endtask

  task automatic test_flush_resp();
    logic [31:0] a, b;
    int w;
    a = $urandom; b = $urandom;
    resp_ready_i = 1'b0;
    issue(a, b, 7'h7, 2'b01);
    wait_resp(20, w);
    resp_ready_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fr_ready: got %b expected 0", req_ready_o); end
    step();
    flush_i = 1'b0;
    resp_ready_i = 1'b0;
    #1;
    checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL fr_idle: got valid %b busy %b expected 0 0", resp_valid_o, busy_o); end
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL fr_count: got %h expected %h", op_count_o, exp_count); end
    checks++; if (resp_result_o !== (a ^ b)) begin errors++; $display("FAIL fr_result_kept: got %h expected %h", resp_result_o, a ^ b); end
    flush_i = 1'b1;
    drive_req(~a, b, 7'h55, 2'b10);
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fi_ready: got %b expected 0", req_ready_o); end
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || mult_en_o !== 1'b0) begin errors++; $display("FAIL fi_not_accepted: got busy %b en %b expected 0 0", busy_o, mult_en_o); end
    checks++; if (mult_op_a_o !== a) begin errors++; $display("FAIL fi_regs_kept: got %h expected %h", mult_op_a_o, a); end
  endtask

  task automatic test_random();
    logic        have_op, rv, rr, exp_valid, exp_en, exp_ready;
    int          t_acc;
    logic [31:0] e_res, e_a, ra, rb;
    logic [OW-1:0] e_op, rop;
    have_op = 1'b0; t_acc = 0; e_res = '0; e_a = '0; e_op = '0;
    for (int i = 0; i < 300; i++) begin
      rv  = (i < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
      rr  = (i < 290) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ra  = $urandom; rb = $urandom; rop = OW'($urandom);
      drive_req(ra, rb, rop, SW'($urandom));
      req_valid_i  = rv;
      resp_ready_i = rr;
      #1;
      exp_valid = have_op && (cyc >= t_acc + L + 1);
      exp_en    = have_op && (cyc <= t_acc + L);
      exp_ready = !have_op || (exp_valid && rr);
      checks++; if (resp_valid_o !== exp_valid || mult_en_o !== exp_en || req_ready_o !== exp_ready || busy_o !== have_op)
        begin errors++; $display("FAIL rnd_ctrl cycle %0d: got v%b e%b r%b b%b expected v%b e%b r%b b%b", i,
          resp_valid_o, mult_en_o, req_ready_o, busy_o, exp_valid, exp_en, exp_ready, have_op); end
      checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL rnd_count cycle %0d: got %h expected %h", i, op_count_o, exp_count); end
      if (exp_valid) begin
        checks++; if (resp_result_o !== e_res) begin errors++; $display("FAIL rnd_result cycle %0d: got %h expected %h", i, resp_result_o, e_res); end
      end
      if (exp_en) begin
        checks++; if (mult_op_a_o !== e_a || mult_operator_o !== e_op)
          begin errors++; $display("FAIL rnd_mult_regs cycle %0d: got %h %h expected %h %h", i, mult_op_a_o, mult_operator_o, e_a, e_op); end
      end
      if (exp_valid && rr) begin exp_count++; have_op = 1'b0; end
      if (rv && exp_ready) begin have_op = 1'b1; t_acc = cyc; e_res = ra ^ rb; e_a = ra; e_op = rop; end
      step();
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] a;
    int w;
    resp_ready_i = 1'b1;
    step();
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    #1;
    exp_count = 16'hFFFF;
    checks++; if (op_count_o !== exp_count) begin errors++; $display("FAIL wrap_preload: got %h expected %h", op_count_o, exp_count); end
    a = $urandom;
    issue(a, ~a, 7'h4, 2'b01);
    wait_resp(20, w);
    checks++; if (resp_result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_result: got %h expected ffffffff", resp_result_o); end
    step();
    exp_count++;
    checks++; if (op_count_o !== 16'h0000 || op_count_o !== exp_count) begin errors++; $display("FAIL wrap_count: got %h expected 0000", op_count_o); end
    issue(a, 32'h1234_5678, 7'h7F, 2'b11);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    #1;
    exp_count = 16'd0;
    checks++; if (mult_en_o !== 1'b0 || resp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1)
      begin errors++; $display("FAIL mreset_ctrl: got en %b v %b b %b r %b expected 0 0 0 1", mult_en_o, resp_valid_o, busy_o, req_ready_o); end
    checks++; if ({mult_op_a_o, mult_op_b_o, mult_operator_o, mult_signed_o} !== '0)
      begin errors++; $display("FAIL mreset_regs: got %h %h %h %h expected 0", mult_op_a_o, mult_op_b_o, mult_operator_o, mult_signed_o); end
    checks++; if (resp_result_o !== 32'd0 || op_count_o !== exp_count)
      begin errors++; $display("FAIL mreset_result_count: got %h %h expected 0 0", resp_result_o, op_count_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush_busy();
    test_flush_resp();
    test_random();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ibex_pext_mult_seq.md
Name: ibex_pext_mult_seq

Overview:
Initiator-side sequencer for the multi-cycle P-extension multiplier. It accepts one P-ext multiply request per handshake from the ID/EX stage and drives the multiplier's enable, operands, operator and signedness. It holds them stable for a fixed number of cycles, then captures the multiplier result and presents it on a valid/ready response port to the P-ext ALU or writeback path.
It sits between the decoder/EX stage and the P-ext multiplier. The multiplier itself is not part of this block.

Parameters:
MultLatency, 2, cycles mult_en_o is held before mult_result_i is sampled; legal range 1..15.
OpWidth, 7, width of the P-ext operator encoding.
SignWidth, 2, width of the signed-operand type encoding.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  kill in-flight operation and pending response
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_a_i  in  32  operand A
req_op_b_i  in  32  operand B
req_operator_i  in  OpWidth  P-ext operator
req_signed_i  in  SignWidth  signed-operand type
mult_en_o  out  1  multiplier enable
mult_op_a_o  out  32  registered operand A to multiplier
mult_op_b_o  out  32  registered operand B to multiplier
mult_operator_o  out  OpWidth  registered operator
mult_signed_o  out  SignWidth  registered signedness
mult_result_i  in  32  multiplier result
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed when valid&ready
resp_result_o  out  32  captured result
busy_o  out  1  state != IDLE
op_count_o  out  16  completed-response counter

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at an edge): state=IDLE, cnt=0, all registered mult_* outputs=0, resp_result_o=0, op_count_o=0.
  - After reset: mult_en_o=0, resp_valid_o=0, busy_o=0, req_ready_o=1 (unless flush_i=1).
- FSM states are IDLE, BUSY and RESP.
- Combinational outputs:
  - req_ready_o = !flush_i & (IDLE | (RESP & resp_ready_i)).
  - mult_en_o = (state==BUSY).
  - resp_valid_o = (state==RESP).
- IDLE: on req_valid_i & req_ready_o, register operands, operator and signedness into mult_*. Load cnt=MultLatency-1. Go to BUSY.
- BUSY:
  - mult_* are held stable; new requests are ignored (req_ready_o=0).
  - If cnt!=0, cnt decrements by one.
  - If cnt==0, sample mult_result_i into resp_result_o and go to RESP.
- RESP:
  - resp_result_o is held stable until resp_valid_o & resp_ready_i.
  - On that handshake, op_count_o increments, wrapping 0xFFFF→0x0000.
  - If a new request handshakes in the same cycle, load it and go to BUSY (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- Latency: accept at cycle T → mult_en_o=1 for cycles T+1..T+MultLatency → resp_valid_o=1 from T+MultLatency+1.
  - Minimum accept-to-accept spacing is MultLatency+1 cycles with resp_ready_i tied high.
- flush_i:
  - Highest priority below reset. From any state, next state is IDLE and cnt=0.
  - No response is produced and op_count_o is not incremented, even if resp_ready_i=1 in RESP.
  - mult_* registers keep their values; only mult_en_o drops.
  - Flush in the same cycle as req_valid_i: the request is not accepted.
- mult_* registers update only on an accepted request.
- resp_result_o updates only on BUSY with cnt==0.
- No combinational path from mult_result_i to any output.
- Counter: cnt width $clog2(MultLatency+1); MultLatency=1 means a single BUSY cycle.

Test Plan:
1. Reset then single op. Bench multiplier returns A^B. Drive A=0x820111dc, B=0x05057fca, resp_ready_i=1, MultLatency=2, request accepted at T. Required: mult_en_o high at T+1 and T+2; resp_valid_o at T+3 with resp_result_o=0x87046e16; op_count_o=1.
2. Backpressure: hold resp_ready_i=0 for 5 cycles in RESP. Required: resp_valid_o and resp_result_o stable throughout, req_ready_o=0, mult_en_o=0. After release: op_count_o increments once and state returns to IDLE.
3. Back-to-back: req_valid_i held high with two requests. Required: second accepted in the same cycle as the first response handshake; mult_en_o low for exactly one cycle between bursts; results returned in order.
4. Flush mid-BUSY (cycle T+1). Required: next cycle busy_o=0, mult_en_o=0, no resp_valid_o ever for that op, op_count_o unchanged. A new request issued afterwards completes normally.
5. Flush in RESP with resp_ready_i=1, and flush with req_valid_i=1 in IDLE. Required: no count increment; request not accepted (req_ready_o=0).
6. Wrap and mid-operation reset:
   - Preload op_count_o to 0xFFFF via 65535 ops (or force); next response gives 0x0000.
   - Assert rst_ni=0 during BUSY for one edge; all outputs take their reset values on that edge.
